dsp_mac_sequencer: RTL and testbench
====================================

# dsp_mac_sequencer

Sequencer that drives one `dsp_slice` as a dot-product engine. It accepts a job (vector length), streams operand pairs in over a valid/ready handshake, and schedules the slice's `multiply`/`accumulate` controls against the slice's 3-register pipeline. The first product of each job is loaded into the slice accumulator, later products are accumulated, and the final result is returned over a valid/ready output. It sits between the activation/weight feeders and one slice instance.

## Interface
- `DWIDTH`, 8: operand/result width; must equal the slice's width.
- `LEN_W`, 16: width of the job length field.

- `clk`  in  1  clock; every register is rising-edge.
- `reset`  in  1  asynchronous, active-low; clears all state.
- `start`  in  1  job request; sampled only in IDLE.
- `len`  in  LEN_W  number of operand pairs, sampled with `start`.
- `busy`  out  1  high in every state except IDLE.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  high only in RUN.
- `in_a`, `in_b`  in  DWIDTH  signed operands.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  result consumed.
- `out_data`  out  DWIDTH  equals `dsp_result`.
- `out_carry`  out  1  sticky OR of `dsp_carry_out` over the job's accumulate cycles.
- `dsp_ax`  out  DWIDTH  tied to 0.
- `dsp_ay`, `dsp_az`  out  DWIDTH  registered operands.
- `dsp_carry_in`  out  1  tied to 0.
- `dsp_multiply`, `dsp_accumulate`  out  1  slice controls.
- `dsp_result`  in  DWIDTH  slice result register.
- `dsp_carry_out`  in  1  slice adder carry.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - `start` with `len != 0` captures `len` into the remaining counter, clears `out_carry`, and moves to RUN.
  - `start` with `len == 0` is ignored.
- RUN:
  - A beat is accepted on each edge where `in_valid & in_ready` is high.
  - On accept, `in_a`/`in_b` are registered onto `dsp_ay`/`dsp_az` and the remaining counter decrements.
  - A tag {valid, first, last} enters a 3-stage tag pipe, t1→t2→t3. `first` marks the job's first beat; `last` marks the beat that takes the counter to 0.
  - On the accept of the last beat, the FSM moves to DRAIN.
- Bubble: on any edge with no accept, `dsp_ay`/`dsp_az` load 0 and a tag with valid=0 enters the pipe.
- Slice control, from t3:
  - `dsp_accumulate` = 1 always.
  - `dsp_multiply` = t3.valid & t3.first, which loads the product and discards the prior accumulator.
  - In all other cycles the slice adds its product, which is 0 for a bubble.
- Carry: `out_carry` |= `dsp_carry_out` in cycles where t3.valid & !t3.first.
- DRAIN: on the edge where t3.valid & t3.last is high, set `out_valid` and move to DONE.
- DONE:
  - `out_valid` holds and `out_data`/`out_carry` are stable.
  - The edge where `out_ready` is high clears `out_valid` and returns the FSM to IDLE.
- Arithmetic is the slice's own: the product is saturated to DWIDTH, and the sum wraps mod 2^DWIDTH. `out_carry` is unsigned carry, not signed overflow.
- Reset (asynchronous, at any point, including mid-job):
  - State → IDLE; counter, tag pipe, `dsp_ay`, `dsp_az` → 0.
  - `out_valid`, `out_carry`, `in_ready`, `busy`, `dsp_multiply` → 0; `dsp_accumulate` → 1.
  - The next job's first-beat load makes stale slice accumulator contents irrelevant.

## Timing
- `start` on edge S → RUN; `in_ready` is high from the cycle after S. There is no accept on edge S.
- Last beat accepted on edge E:
  - `dsp_ay`/`dsp_az` are valid after E.
  - The slice input flops load on E+1 and the product register on E+2.
  - Control is applied during the E+2..E+3 cycle, and the result register loads on E+3.
- `out_valid` rises after edge E+3, coincident with the final `dsp_result`.
- A back-to-back job of length L: `out_valid` rises after edge S+L+3.
- `start` is ignored in RUN, DRAIN and DONE.
- A new job may start on the edge after `out_ready` clears DONE.

## Test plan
- Reset then idle → all outputs 0 except `dsp_accumulate`=1; `busy`=0.
- `len`=3, pairs (1,2),(3,4),(5,6) streamed back-to-back → `out_data`=0x2C, `out_carry`=0, `out_valid` rising after S+6.
- Same job with `in_valid` low for 2 cycles between each beat → `out_data`=0x2C; `out_valid` delayed by exactly 4 cycles.
- `len`=3, all pairs (16,16) → each product saturates to 0x7F; `out_data`=0x7D, `out_carry`=1.
- Two jobs: first (2,3) with `len`=1, then (-2,3) with `len`=1 → results 0x06 then 0xFA. Second job is unaffected by the first. `start` pulsed in DONE is ignored.
- `reset` asserted during RUN after 1 of 3 beats, then a `len`=1 (7,1) job → `out_data`=0x07; no `out_valid` from the aborted job.

Source files
------------

// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer: drives one dsp_slice as a dot-product engine.
// Ports: job (start/len/busy), operand stream (in_*), result (out_*), slice (dsp_*).
module dsp_mac_sequencer #(
  parameter int DWIDTH = 8,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] in_a,
  input  logic [DWIDTH-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_carry,
  output logic [DWIDTH-1:0] dsp_ax,
  output logic [DWIDTH-1:0] dsp_ay,
  output logic [DWIDTH-1:0] dsp_az,
  output logic              dsp_carry_in,
  output logic              dsp_multiply,
  output logic              dsp_accumulate,
  input  logic [DWIDTH-1:0] dsp_result,
  input  logic              dsp_carry_out
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  state_e            state_q;
  logic [LEN_W-1:0]  cnt_q;
  logic              first_q;
  logic [2:0]        tv_q;
  logic [2:0]        tf_q;
  logic [2:0]        tl_q;
  logic [DWIDTH-1:0] ay_q;
  logic [DWIDTH-1:0] az_q;
  logic              out_valid_q;
  logic              out_carry_q;

  logic accept;
  logic last_beat;
  logic t3_last;
  logic t3_acc;

  assign accept    = in_valid & (state_q == RUN);
  assign last_beat = (cnt_q == LEN_W'(1));
  assign t3_last   = tv_q[2] & tl_q[2];
  // t3 beats after the first add into the accumulator
  assign t3_acc    = tv_q[2] & ~tf_q[2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      first_q     <= 1'b0;
      tv_q        <= '0;
      tf_q        <= '0;
      tl_q        <= '0;
      ay_q        <= '0;
      az_q        <= '0;
      out_valid_q <= 1'b0;
      out_carry_q <= 1'b0;
    end else begin
      // bubbles feed zeros so the slice adds a zero product
      tv_q <= {tv_q[1:0], accept};
      tf_q <= {tf_q[1:0], accept & first_q};
      tl_q <= {tl_q[1:0], accept & last_beat};
      ay_q <= accept ? in_a : '0;
      az_q <= accept ? in_b : '0;
      if (t3_acc) begin
        out_carry_q <= out_carry_q | dsp_carry_out;
      end
      unique case (state_q)
        IDLE: begin
          if (start && (len != '0)) begin
            cnt_q       <= len;
            first_q     <= 1'b1;
            out_carry_q <= 1'b0;
            state_q     <= RUN;
          end
        end
        RUN: begin
          if (accept) begin
            cnt_q   <= cnt_q - LEN_W'(1);
            first_q <= 1'b0;
            if (last_beat) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (t3_last) begin
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
      endcase
    end
  end

  assign busy           = (state_q != IDLE);
  assign in_ready       = (state_q == RUN);
  assign out_valid      = out_valid_q;
  assign out_data       = dsp_result;
  assign out_carry      = out_carry_q;
  assign dsp_ax         = '0;
  assign dsp_ay         = ay_q;
  assign dsp_az         = az_q;
  assign dsp_carry_in   = 1'b0;
  // first product replaces the accumulator, later ones add
  assign dsp_multiply   = tv_q[2] & tf_q[2];
  assign dsp_accumulate = 1'b1;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// tb_dsp_mac_sequencer: directed bench with a behavioural dsp_slice.
// Slice: input flops, saturating product register, wrapping accumulator.
module tb_dsp_mac_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] len = '0;
  logic        busy;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_a = '0;
  logic [7:0]  in_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic        out_carry;
  logic [7:0]  dsp_ax;
  logic [7:0]  dsp_ay;
  logic [7:0]  dsp_az;
  logic        dsp_carry_in;
  logic        dsp_multiply;
  logic        dsp_accumulate;
  logic [7:0]  dsp_result;
  logic        dsp_carry_out;

  int n_assert = 0;
  int n_fail = 0;
  int lat;
  logic [7:0] va [0:3];
  logic [7:0] vb [0:3];

  always #5 clk = ~clk;

  dsp_mac_sequencer #(.DWIDTH(8), .LEN_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_carry(out_carry), .dsp_ax(dsp_ax), .dsp_ay(dsp_ay),
    .dsp_az(dsp_az), .dsp_carry_in(dsp_carry_in),
    .dsp_multiply(dsp_multiply), .dsp_accumulate(dsp_accumulate),
    .dsp_result(dsp_result), .dsp_carry_out(dsp_carry_out)
  );

  // behavioural slice; accumulator starts with junk on purpose
  logic [7:0] s_ax = 8'h00;
  logic [7:0] s_ay = 8'h00;
  logic [7:0] s_az = 8'h00;
  logic [7:0] s_prod = 8'h00;
  logic [7:0] s_res = 8'h55;
  logic [8:0] s_sum;

  function automatic logic [7:0] sat_mul(input logic signed [7:0] a,
                                         input logic signed [7:0] b);
    logic signed [15:0] p;
    p = a * b;
    if (p > 16'sd127) return 8'h7F;
    if (p < -16'sd128) return 8'h80;
    return p[7:0];
  endfunction

  assign s_sum = {1'b0, s_res} + {1'b0, s_prod} + {1'b0, s_ax}
               + {8'b0, dsp_carry_in};
  assign dsp_carry_out = s_sum[8];
  assign dsp_result = s_res;

  always @(posedge clk) begin
    s_ax <= dsp_ax;
    s_ay <= dsp_ay;
    s_az <= dsp_az;
    s_prod <= sat_mul(s_ay, s_az);
    if (dsp_accumulate) begin
      s_res <= dsp_multiply ? s_prod : s_sum[7:0];
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // start on edge S, stream n beats with gap idle cycles between them;
  // lat = edges after S until out_valid is seen (bounded)
  task automatic job(input int n, input int gap, output int lat_o);
    start = 1'b1;
    len = 16'(n);
    tick;
    start = 1'b0;
    lat_o = 0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          in_valid = 1'b0;
          tick;
          lat_o++;
        end
      end
      in_valid = 1'b1;
      in_a = va[i];
      in_b = vb[i];
      tick;
      lat_o++;
    end
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    while (!out_valid && lat_o < 60) begin
      tick;
      lat_o++;
    end
  endtask

  task automatic release_result;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk("release_valid", int'(out_valid), 0);
    chk("release_busy", int'(busy), 0);
  endtask

  initial begin
    #12;
    chk("rst_busy", int'(busy), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_carry", int'(out_carry), 0);
    chk("rst_ay", int'(dsp_ay), 0);
    chk("rst_az", int'(dsp_az), 0);
    chk("rst_ax", int'(dsp_ax), 0);
    chk("rst_cin", int'(dsp_carry_in), 0);
    chk("rst_mul", int'(dsp_multiply), 0);
    chk("rst_acc", int'(dsp_accumulate), 1);
    reset = 1'b1;
    tick;
    tick;
    chk("idle_busy", int'(busy), 0);

    start = 1'b1;
    len = 16'd0;
    tick;
    start = 1'b0;
    chk("len0_ignored", int'(busy), 0);

    va[0] = 8'd1; vb[0] = 8'd2;
    va[1] = 8'd3; vb[1] = 8'd4;
    va[2] = 8'd5; vb[2] = 8'd6;
    job(3, 0, lat);
    chk("b2b_lat", lat, 6);
    chk("b2b_data", int'(out_data), 'h2C);
    chk("b2b_carry", int'(out_carry), 0);
    tick;
    chk("done_hold_valid", int'(out_valid), 1);
    chk("done_hold_data", int'(out_data), 'h2C);
    chk("done_in_ready", int'(in_ready), 0);
    release_result();
    tick;

    job(3, 2, lat);
    chk("gap_lat", lat, 10);
    chk("gap_data", int'(out_data), 'h2C);
    chk("gap_carry", int'(out_carry), 0);
    release_result();

    va[0] = 8'd16; vb[0] = 8'd16;
    va[1] = 8'd16; vb[1] = 8'd16;
    va[2] = 8'd16; vb[2] = 8'd16;
    job(3, 0, lat);
    chk("sat_lat", lat, 6);
    chk("sat_data", int'(out_data), 'h7D);
    chk("sat_carry", int'(out_carry), 1);
    release_result();

    va[0] = 8'd2; vb[0] = 8'd3;
    job(1, 0, lat);
    chk("j1_lat", lat, 4);
    chk("j1_data", int'(out_data), 'h06);
    chk("j1_carry", int'(out_carry), 0);
    start = 1'b1;
    len = 16'd2;
    tick;
    start = 1'b0;
    chk("done_start_valid", int'(out_valid), 1);
    chk("done_start_busy", int'(busy), 1);
    chk("done_start_rdy", int'(in_ready), 0);
    release_result();
    va[0] = 8'hFE; vb[0] = 8'd3;
    job(1, 0, lat);
    chk("j2_lat", lat, 4);
    chk("j2_data", int'(out_data), 'hFA);
    chk("j2_carry", int'(out_carry), 0);
    release_result();

    va[0] = 8'd4; vb[0] = 8'd5;
    start = 1'b1;
    len = 16'd3;
    tick;
    start = 1'b0;
    in_valid = 1'b1;
    in_a = va[0];
    in_b = vb[0];
    tick;
    in_valid = 1'b0;
    chk("mid_ay", int'(dsp_ay), 4);
    chk("mid_busy", int'(busy), 1);
    reset = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_in_ready", int'(in_ready), 0);
    chk("abort_ay", int'(dsp_ay), 0);
    chk("abort_valid", int'(out_valid), 0);
    chk("abort_acc", int'(dsp_accumulate), 1);
    tick;
    reset = 1'b1;
    tick;
    for (int k = 0; k < 6; k++) begin
      tick;
      chk("abort_no_valid", int'(out_valid), 0);
    end
    va[0] = 8'd7; vb[0] = 8'd1;
    job(1, 0, lat);
    chk("post_rst_lat", lat, 4);
    chk("post_rst_data", int'(out_data), 'h07);
    chk("post_rst_carry", int'(out_carry), 0);
    release_result();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
